// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, direct-mapped one-word-per-line
// instruction cache, and a byte-serial miss fill from the memory controller.
module if_stage #(
    parameter int          IDX_W    = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        b_flag_i,
    input  logic [31:0] b_target_i,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        stall_req_o
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        buf_q, buf_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]   tag_ram  [LINES];
    logic [31:0]        data_ram [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill_last;
    logic               line_we;
    logic [31:0]        redirect_pc;

    assign idx         = pc_q[IDX_W+1:2];
    assign tag         = pc_q[31:IDX_W+2];
    assign hit         = valid_q[idx] && (tag_ram[idx] == tag);
    assign fill_last   = (state_q == S_FILL) && mem_ready_i && (cnt_q == 2'd3);
    // A redirect coinciding with the last beat discards the line.
    assign line_we     = rst && fill_last && !b_flag_i;
    assign redirect_pc = b_target_i & ~32'd3;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    if (!stall_i) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else begin
                    state_d = S_FILL;
                    cnt_d   = 2'd0;
                end
            end
            S_FILL: begin
                if (mem_ready_i) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    buf_d[7:0]   = mem_data_i;
                        2'd1:    buf_d[15:8]  = mem_data_i;
                        2'd2:    buf_d[23:16] = mem_data_i;
                        default: begin
                            state_d      = S_IDLE;
                            valid_d[idx] = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (b_flag_i) begin
            pc_d    = redirect_pc;
            state_d = S_IDLE;
            cnt_d   = 2'd0;
            valid_d = valid_q;
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = 32'd0;
        if_pc_o     = 32'd0;
        if_inst_o   = 32'd0;
        stall_req_o = 1'b0;
        if (rst) begin
            if_pc_o = pc_q;
            if ((state_q == S_IDLE) && hit) begin
                if_inst_o = data_ram[idx];
            end else begin
                stall_req_o = 1'b1;
            end
            if (state_q == S_FILL) begin
                mem_req_o  = 1'b1;
                mem_addr_o = pc_q + {30'd0, cnt_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 2'd0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // The final byte goes straight from the bus into the top lane.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_ram[idx]  <= tag;
            data_ram[idx] <= {mem_data_i, buf_q};
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a byte-serial memory responder, a queue of
// expected (pc, inst) deliveries, and a monitor that pops on each delivery.
module tb_if_stage;

    localparam int IDX_W = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        b_flag_i;
    logic [31:0] b_target_i;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stall_req_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;

    always #5 clk = ~clk;

    if_stage #(.IDX_W(IDX_W), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .b_flag_i    (b_flag_i),
        .b_target_i  (b_target_i),
        .mem_ready_i (mem_ready_i),
        .mem_data_i  (mem_data_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .if_pc_o     (if_pc_o),
        .if_inst_o   (if_inst_o),
        .stall_req_o (stall_req_o)
    );

    // Memory image: a fixed instruction at word 0, a hash everywhere else.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'd0) return 32'h00500093;
        return (w * 32'h9E3779B1) ^ {w[15:0], w[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a) >> (8 * a[1:0]);
        return w[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    task automatic push_run(input logic [31:0] tgt, input int len);
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            a = (tgt & ~32'd3) + 32'(4 * i);
            exp_q.push_back('{pc: a, inst: mem_word(a)});
        end
    endtask

    // Called at posedge+1; the redirect takes effect at the next posedge.
    task automatic start_run(input logic [31:0] tgt, input int len);
        exp_q.delete();
        push_run(tgt, len);
        stall_i    = 1'b0;
        b_flag_i   = 1'b1;
        b_target_i = tgt;
        @(posedge clk);
        #1;
        b_flag_i   = 1'b0;
        b_target_i = $urandom;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() > 0) begin
            if (n >= budget) begin
                timeout("run_done");
                exp_q.delete();
                break;
            end
            if (rnd) begin
                if ($urandom_range(0, 29) == 0) return;
                stall_i = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        stall_i = 1'b1;
    endtask

    task automatic wait_beats(input int cnt);
        int base;
        int n;
        base = beats;
        n = 0;
        while (beats - base < cnt) begin
            if (n >= 200) begin
                timeout("beats");
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req_o) begin
            if (n >= 50) begin
                timeout("mem_req");
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] base;
        case ($urandom_range(0, 6))
            0:       base = 32'h0;
            1:       base = 32'h200;
            2:       base = 32'h1F8;
            3:       base = 32'hFFFFFFF4;
            4:       base = 32'h3F0;
            default: base = 32'($urandom_range(0, 4095));
        endcase
        return (base & ~32'd3) | 32'($urandom_range(0, 3));
    endfunction

    // Memory controller: random acceptance, byte driven for the current address.
    initial begin
        mem_ready_i = 1'b0;
        mem_data_i  = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_o) begin
                mem_ready_i = ($urandom_range(0, 2) != 0);
                mem_data_i  = mem_byte(mem_addr_o);
            end else begin
                mem_ready_i = 1'b0;
                mem_data_i  = 8'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && mem_req_o && mem_ready_i) beats++;
        end
    end

    // Monitor: a delivery is a presented hit with no stall and no redirect.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (!mem_req_o) check("addr_when_idle", mem_addr_o, 32'd0);
                if (mem_req_o) check("stall_during_fill", {31'd0, stall_req_o}, 32'd1);
                if (stall_req_o) begin
                    check("bubble_inst", if_inst_o, 32'd0);
                end else if (!b_flag_i) begin
                    if (exp_q.size() > 0) begin
                        check("if_pc", if_pc_o, exp_q[0].pc);
                        check("if_inst", if_inst_o, exp_q[0].inst);
                        if (!stall_i) void'(exp_q.pop_front());
                    end else if (!stall_i) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_delivery: got pc %h inst %h, expected none",
                                 if_pc_o, if_inst_o);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        stall_i    = 1'b0;
        b_flag_i   = 1'b0;
        b_target_i = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc", if_pc_o, 32'd0);
        check("rst_inst", if_inst_o, 32'd0);
        check("rst_stall", {31'd0, stall_req_o}, 32'd0);
        check("rst_req", {31'd0, mem_req_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);

        // Cold fetch from the reset PC.
        @(posedge clk);
        #1;
        push_run(32'h0, 1);
        rst = 1'b1;
        wait_beats(4);
        @(negedge clk);
        check("t1_stall", {31'd0, stall_req_o}, 32'd0);
        check("t1_inst", if_inst_o, 32'h00500093);
        @(posedge clk);
        #1;
        stall_i = 1'b1;
        @(negedge clk);
        check("t1_next_pc", if_pc_o, 32'h4);
        @(posedge clk);
        #1;

        // Loop back: hit without a memory request.
        start_run(32'h0, 1);
        @(negedge clk);
        check("t2_hit_stall", {31'd0, stall_req_o}, 32'd0);
        check("t2_hit_req", {31'd0, mem_req_o}, 32'd0);
        check("t2_hit_inst", if_inst_o, mem_word(32'h0));
        @(posedge clk);
        #1;
        wait_done(100, 1'b0);

        // Redirect after two beats of a fill.
        start_run(32'h8, 1);
        wait_beats(2);
        start_run(32'h103, 1);
        @(negedge clk);
        check("t3_req_drop", {31'd0, mem_req_o}, 32'd0);
        check("t3_pc", if_pc_o, 32'h100);
        check("t3_miss", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk);
        #1;
        wait_req();
        check("t3_fill_addr", mem_addr_o, 32'h100);
        wait_done(200, 1'b0);
        start_run(32'h0, 1);
        @(negedge clk);
        check("t3_line0_kept", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk);
        #1;
        wait_done(100, 1'b0);

        // Aliasing: 0x200 evicts line 0.
        start_run(32'h200, 1);
        wait_done(200, 1'b0);
        start_run(32'h0, 1);
        @(negedge clk);
        check("t4_alias_miss", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk);
        #1;
        wait_done(200, 1'b0);

        // Downstream hold on a hit.
        start_run(32'h0, 2);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_hold_pc", if_pc_o, 32'h0);
            check("t5_hold_inst", if_inst_o, mem_word(32'h0));
            @(posedge clk);
            #1;
        end
        stall_i = 1'b0;
        wait_done(200, 1'b0);

        // Randomized runs with stalls and mid-run redirects.
        for (int r = 0; r < 60; r++) begin
            start_run(pick_target(), $urandom_range(1, 6));
            wait_done(600, 1'b1);
        end
        stall_i = 1'b1;

        // Reset in the middle of a fill invalidates every line.
        start_run(32'h0, 1);
        wait_done(200, 1'b0);
        start_run(32'h12340, 1);
        wait_req();
        wait_beats(1);
        rst = 1'b0;
        exp_q.delete();
        stall_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_req", {31'd0, mem_req_o}, 32'd0);
        check("t6_pc_out", if_pc_o, 32'd0);
        check("t6_stall_out", {31'd0, stall_req_o}, 32'd0);
        @(posedge clk);
        #1;
        push_run(32'h0, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_pc", if_pc_o, 32'd0);
        check("t6_invalid", {31'd0, stall_req_o}, 32'd1);
        @(posedge clk);
        #1;
        wait_done(200, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
